uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a write-side FIFO, configurable word length, optional parity and one or two stop bits. It sits between the on-chip producers (the SPI bridge, debug logic) and the board TX pin. Producers queue words with a valid/ready handshake instead of holding a data bus stable for a whole frame. Frames are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small write-side FIFO.
// Frames go out back-to-back while words are queued; tx idles high.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int unsigned frequency       = 27_000_000,
  parameter int unsigned transfer_speed  = 4800,
  parameter int unsigned package_size    = 8,
  parameter int unsigned stop_bits       = 1,
  parameter int unsigned fifo_depth_log2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [package_size-1:0]   data,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic                      parity_odd,
  output logic                      tx,
  output logic                      busy,
  output logic [fifo_depth_log2:0]  fifo_count
);

  localparam int unsigned CNT   = frequency / transfer_speed;
  localparam int unsigned TW    = $clog2(CNT);
  localparam int unsigned DEPTH = 1 << fifo_depth_log2;
  localparam int unsigned PW    = fifo_depth_log2;
  localparam int unsigned CW    = fifo_depth_log2 + 1;
  localparam int unsigned BW    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [package_size-1:0] shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [package_size-1:0] mem_q [DEPTH];
  logic                    push, pop, tick;

`ifdef UART_TX_PARITY_EN
  logic                    par_q, par_d;
`else
  logic                    unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Next-state logic for the frame FSM, bit timer and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    push     = data_valid && ready_q;
    tick     = (timer_q == TW'(CNT - 1));
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    if (state_q != ST_IDLE) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_START;
          tx_d    = 1'b0;
          timer_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == BW'(package_size - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
            bit_d   = '0;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
`else
        state_d = ST_IDLE;
        tx_d    = 1'b1;
`endif
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == BW'(stop_bits - 1)) begin
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        timer_d = '0;
      end
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = (^mem_q[rd_ptr_q]) ^ parity_odd;
`endif
    end

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ready_d  = (count_d != CW'(DEPTH));
    busy_d   = (state_d != ST_IDLE) || (count_d != '0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage; contents need no reset, pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign data_ready = ready_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (16 clk/bit, 8 data bits, depth 4).
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int BIT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB    = 10 + P;
  localparam int FRAME = NB * BIT;
  localparam int NB2   = 11 + P;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       parity_odd;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  logic [7:0] data2;
  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;
  logic [2:0] count2;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo #(
    .frequency(16), .transfer_speed(1), .package_size(8),
    .stop_bits(1), .fifo_depth_log2(2)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .parity_odd(parity_odd), .tx(tx),
    .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(
    .frequency(16), .transfer_speed(1), .package_size(8),
    .stop_bits(2), .fifo_depth_log2(2)
  ) dut2 (
    .clk(clk), .rst(rst), .data(data2), .data_valid(valid2),
    .data_ready(ready2), .parity_odd(parity_odd), .tx(tx2),
    .busy(busy2), .fifo_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected frame, bit 0 = start bit, one stop bit
  function automatic logic [15:0] frame_bits(input logic [7:0] w, input logic odd);
    logic [15:0] f;
    f = '0;
    f[8:1] = w;
    if (P == 1) f[9] = (^w) ^ odd;
    f[9 + P] = 1'b1;
    return f;
  endfunction

  // Observe nb bit periods starting at the current cycle; counts in-bit changes
  task automatic sample_bits(input int nb, output logic [15:0] bits,
                             output int bad, output logic busy_last);
    bits = '0;
    bad = 0;
    busy_last = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < BIT; c++) begin
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) bad++;
        if (b == nb - 1 && c == BIT - 1) busy_last = busy;
        tick();
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; data_valid = 1'b0; valid2 = 1'b0;
    data = '0; data2 = '0; parity_odd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", data_ready); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    vectors++; if (tx2 !== 1'b1 || busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_dut2: tx2=%b busy2=%b want 1/0", tx2, busy2); end
    tick();
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_idle_tx: got %b want 1", tx); end
  endtask

  task automatic test_single_word;
    logic [15:0] bits;
    logic [15:0] exp;
    int bad;
    logic bl;
    data = 8'hA5; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL single_count_after_push: got %0d want 1", fifo_count); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_after_push: got %b want 1", tx); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_after_push: got %b want 1", busy); end
    tick();
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_start_latency: got %b want 0", tx); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL single_count_after_pop: got %0d want 0", fifo_count); end
    sample_bits(NB, bits, bad, bl);
    exp = frame_bits(8'hA5, 1'b0);
    vectors++; if (bits !== exp) begin miscompares++; $display("FAIL single_bits: got %h want %h", bits, exp); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL single_bit_width: %0d off-level cycles want 0", bad); end
    vectors++; if (bl !== 1'b1) begin miscompares++; $display("FAIL single_busy_last_stop: got %b want 1", bl); end
    vectors++; if (busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL single_end: busy=%b tx=%b want 0/1", busy, tx); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [15:0] bits;
    int bad;
    logic bl;
    parity_odd = 1'b0;
    data = 8'h07; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    sample_bits(NB, bits, bad, bl);
    vectors++; if (bits[9] !== 1'b1) begin miscompares++; $display("FAIL parity_even_bit: got %b want 1", bits[9]); end
    vectors++; if (bits !== frame_bits(8'h07, 1'b0) || bad !== 0) begin miscompares++; $display("FAIL parity_even_frame: got %h bad=%0d", bits, bad); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_len: busy=%b want 0 after 176 clocks", busy); end
    parity_odd = 1'b1;
    data = 8'h07; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    parity_odd = 1'b0;
    sample_bits(NB, bits, bad, bl);
    vectors++; if (bits[9] !== 1'b0) begin miscompares++; $display("FAIL parity_odd_bit: got %b want 0", bits[9]); end
    vectors++; if (bl !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL parity_odd_len: busy_last=%b busy=%b want 1/0", bl, busy); end
  endtask
`endif

  task automatic test_back_to_back;
    logic [7:0] w [0:5];
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A};
    fork
      begin
        int guard;
        for (int i = 0; i < 6; i++) begin
          data = w[i]; data_valid = 1'b1;
          if (i == 5) begin
            vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b want 0", data_ready); end
            vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL b2b_count_full: got %0d want 4", fifo_count); end
          end
          guard = 0;
          while (data_ready !== 1'b1 && guard < 2000) begin tick(); guard++; end
          if (i == 5) begin
            vectors++; if (guard !== FRAME - 3) begin miscompares++; $display("FAIL b2b_stall_cycles: got %0d want %0d", guard, FRAME - 3); end
            vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL b2b_count_rerise: got %0d want 3", fifo_count); end
          end
          tick();
        end
        data_valid = 1'b0;
      end
      begin
        int waited;
        logic [15:0] bits;
        int bad;
        logic bl;
        waited = 0;
        while (tx !== 1'b0 && waited < 50) begin tick(); waited++; end
        vectors++; if (waited !== 2) begin miscompares++; $display("FAIL b2b_first_start: got %0d cycles want 2", waited); end
        for (int f = 0; f < 6; f++) begin
          sample_bits(NB, bits, bad, bl);
          vectors++; if (bits !== frame_bits(w[f], 1'b0) || bad !== 0) begin miscompares++; $display("FAIL b2b_frame%0d: got %h bad=%0d want %h", f, bits, bad, frame_bits(w[f], 1'b0)); end
        end
        vectors++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin miscompares++; $display("FAIL b2b_end: busy=%b count=%0d want 0/0", busy, fifo_count); end
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] w [0:3];
    int lows;
    int busys;
    w = '{8'hF7, 8'h11, 8'h22, 8'h33};
    data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin data = w[i]; tick(); end
    data_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL rstmid_queued: got %0d want 3", fifo_count); end
    repeat (67) tick();
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_databit3: got %b want 0", tx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b want 1", data_ready); end
    lows = 0; busys = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      tick();
    end
    vectors++; if (lows !== 0 || busys !== 0) begin miscompares++; $display("FAIL rstmid_quiet: tx low %0d, busy %0d cycles want 0/0", lows, busys); end
  endtask

  task automatic test_two_stop;
    logic h [0:799];
    int s2;
    int run;
    logic [7:0] got;
    data2 = 8'h12; valid2 = 1'b1;
    tick();
    data2 = 8'h5A;
    tick();
    valid2 = 1'b0;
    for (int k = 0; k < 800; k++) begin h[k] = tx2; tick(); end
    vectors++; if (h[0] !== 1'b0) begin miscompares++; $display("FAIL stop2_start: got %b want 0", h[0]); end
    for (int b = 0; b < 8; b++) got[b] = h[BIT * (b + 1) + 8];
    vectors++; if (got !== 8'h12) begin miscompares++; $display("FAIL stop2_data: got %h want 12", got); end
    s2 = -1;
    for (int k = (9 + P) * BIT; k < 800; k++) if (s2 < 0 && h[k] === 1'b0) s2 = k;
    vectors++; if (s2 !== NB2 * BIT) begin miscompares++; $display("FAIL stop2_next_start: got %0d want %0d", s2, NB2 * BIT); end
    run = 0;
    if (s2 > 0) for (int k = s2 - 1; k >= 0 && h[k] === 1'b1; k--) run++;
    vectors++; if (run !== 2 * BIT) begin miscompares++; $display("FAIL stop2_gap: got %0d clocks want %0d", run, 2 * BIT); end
    vectors++; if (h[799] !== 1'b1 || busy2 !== 1'b0 || count2 !== 3'd0) begin miscompares++; $display("FAIL stop2_end: tx=%b busy=%b count=%0d want 1/0/0", h[799], busy2, count2); end
  endtask

  task automatic test_simul_push_pop;
    logic [7:0] w [0:3];
    logic [15:0] bits;
    int bad;
    logic bl;
    w = '{8'h3C, 8'hC3, 8'h69, 8'h96};
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin data = w[i]; tick(); end
    data_valid = 1'b0;
    repeat (FRAME - 2) tick();
    vectors++; if (fifo_count !== 3'd2 || tx !== 1'b1) begin miscompares++; $display("FAIL simul_pre: count=%0d tx=%b want 2/1", fifo_count, tx); end
    data = w[3]; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL simul_count: got %0d want 2", fifo_count); end
    vectors++; if (tx !== 1'b0 || data_ready !== 1'b1) begin miscompares++; $display("FAIL simul_start: tx=%b ready=%b want 0/1", tx, data_ready); end
    for (int f = 1; f < 4; f++) begin
      sample_bits(NB, bits, bad, bl);
      vectors++; if (bits !== frame_bits(w[f], 1'b0) || bad !== 0) begin miscompares++; $display("FAIL simul_order%0d: got %h bad=%0d want %h", f, bits, bad, frame_bits(w[f], 1'b0)); end
    end
    vectors++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin miscompares++; $display("FAIL simul_end: busy=%b count=%0d want 0/0", busy, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single_word();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop();
    test_simul_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
